nand_slot_arbiter: RTL and testbench

Round-robin arbiter that shares the four gates of one 74LS00 quad 2-input NAND package among NUM_REQ requesters.
- Assigns a free gate slot to each accepted request and drives that slot's inputs.
- Holds the inputs stable for SETTLE_CYCLES clock cycles to cover gate propagation delay, then samples the output.
- Returns the result to the owning requester.
- Sits between digital-clock control logic and the gate package, so a single physical package serves several logical NAND users.

---
 rtl/nand_arb_pkg.sv | 22 ++
 rtl/nand_slot_ctrl.sv | 85 ++++++++
 rtl/nand_slot_arbiter.sv | 139 +++++++++++++
 tb/tb_nand_slot_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_arb_pkg.sv
// Shared constants, slot state encoding and width helpers for the NAND slot arbiter.
package nand_arb_pkg;

    // One 74LS00 package provides four 2-input NAND gates.
    localparam int NUM_SLOTS = 4;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_SETTLE = 1'b1
    } slot_state_t;

    // Width of a requester ID; never narrower than one bit.
    function automatic int owner_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Width of the settle counter, which must hold the value SETTLE_CYCLES.
    function automatic int count_width(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/nand_slot_ctrl.sv
// One gate slot: holds operands on the package pins for the settle time,
// then raises a capture strobe naming the owning requester.
module nand_slot_ctrl
    import nand_arb_pkg::*;
#(
    parameter int OWNER_W       = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_a,
    input  logic               load_b,
    input  logic [OWNER_W-1:0] load_owner,
    output logic               slot_a,
    output logic               slot_b,
    output logic               capture,
    output logic [OWNER_W-1:0] owner,
    output slot_state_t        state
);

    localparam int              CNT_W    = count_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

    slot_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               a_q, a_d;
    logic               b_q, b_d;

    // Slot state, counter, owner and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state: load from IDLE, count down in SETTLE, release the pins on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            SLOT_IDLE: begin
                if (load) begin
                    state_d = SLOT_SETTLE;
                    cnt_d   = CNT_INIT;
                    owner_d = load_owner;
                    a_d     = load_a;
                    b_d     = load_b;
                end
            end
            SLOT_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SLOT_IDLE;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // The gate output is sampled at the edge that ends the last settle cycle.
    assign capture = (state_q == SLOT_SETTLE) && (cnt_q == CNT_W'(1));
    assign owner   = owner_q;
    assign slot_a  = a_q;
    assign slot_b  = b_q;
    assign state   = state_q;

endmodule

// File: rtl/nand_slot_arbiter.sv
// Round-robin arbiter sharing the four NAND gates of one 74LS00 among NUM_REQ requesters.
// Handshake: a request transfers in any cycle where req_valid[i] & req_ready[i];
// req_ready depends only on registered state and req_valid, and at most one bit is set.
// rsp_valid[i] is a one-cycle pulse and rsp_y[i] is meaningful only during that pulse.
module nand_slot_arbiter
    import nand_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_a,
    input  logic [NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [NUM_REQ-1:0] rsp_y,
    output logic [3:0]         gate_a,
    output logic [3:0]         gate_b,
    input  logic [3:0]         gate_y,
    output logic [3:0]         slot_busy
);

    localparam int OWNER_W = owner_width(NUM_REQ);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("nand_slot_arbiter: SETTLE_CYCLES must be at least 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("nand_slot_arbiter: NUM_REQ must be in 2..8");
    end

    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] rsp_y_q, rsp_y_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found_req;
    logic               found_slot;
    logic               grant;
    logic [OWNER_W-1:0] winner;
    logic [1:0]         free_slot;
    logic [NUM_SLOTS-1:0] slot_load;
    logic [NUM_SLOTS-1:0] capture;
    logic [OWNER_W-1:0] cap_owner  [NUM_SLOTS];
    slot_state_t        slot_state [NUM_SLOTS];

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        nand_slot_ctrl #(
            .OWNER_W       (OWNER_W),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (slot_load[s]),
            .load_a     (req_a[winner]),
            .load_b     (req_b[winner]),
            .load_owner (winner),
            .slot_a     (gate_a[s]),
            .slot_b     (gate_b[s]),
            .capture    (capture[s]),
            .owner      (cap_owner[s]),
            .state      (slot_state[s])
        );
        assign slot_busy[s] = (slot_state[s] == SLOT_SETTLE);
        assign slot_load[s] = grant && (free_slot == 2'(s));
    end

    // Winner: first eligible requester scanning upward from ptr+1 with wrap-around.
    always_comb begin
        eligible  = req_valid & ~outstanding_q;
        found_req = 1'b0;
        winner    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found_req && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
                found_req = 1'b1;
                winner    = OWNER_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Lowest-numbered free slot; scanning downward leaves the lowest one selected.
    always_comb begin
        found_slot = 1'b0;
        free_slot  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                found_slot = 1'b1;
                free_slot  = 2'(s);
            end
        end
    end

    assign grant     = found_req && found_slot;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    // Response demux from slot captures, outstanding bookkeeping and pointer advance.
    always_comb begin
        ptr_d         = ptr_q;
        outstanding_d = outstanding_q;
        rsp_valid_d   = '0;
        rsp_y_d       = rsp_y_q;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (capture[s] && cap_owner[s] == OWNER_W'(r)) begin
                    rsp_valid_d[r]   = 1'b1;
                    rsp_y_d[r]       = gate_y[s];
                    outstanding_d[r] = 1'b0;
                end
            end
        end
        // A granted requester had outstanding==0, so it cannot also be completing here.
        if (grant) begin
            outstanding_d[winner] = 1'b1;
            ptr_d                 = winner;
        end
    end

    // Arbiter registers; the pointer resets to the last requester so requester 0 leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= OWNER_W'(NUM_REQ - 1);
            outstanding_q <= '0;
            rsp_valid_q   <= '0;
            rsp_y_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            outstanding_q <= outstanding_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_y_q       <= rsp_y_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_nand_slot_arbiter.sv
// Bench for nand_slot_arbiter with a delayed quad-NAND package model,
// a cycle-level reference model and a response scoreboard.
module tb_nand_slot_arbiter;

    localparam int N  = 6;
    localparam int S  = 2;
    localparam int NS = 4;
    localparam int EW = 3 + 32 + 1;   // {requester, due cycle, expected y}

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid, req_a, req_b;
    logic [N-1:0] req_ready, rsp_valid, rsp_y;
    logic [3:0]   gate_a, gate_b, gate_y, slot_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic armed = 1'b0;

    logic [EW-1:0] exp_q[$];

    logic [N-1:0] acc_seen  = '0;
    logic [N-1:0] pend      = '0;
    logic [N-1:0] hold_mask = '0;
    logic [N-1:0] opa       = '0;
    logic [N-1:0] opb       = '0;
    logic         rand_ops  = 1'b0;

    // reference model state
    int           m_rem [NS];
    int           m_own [NS];
    logic         m_a   [NS];
    logic         m_b   [NS];
    logic [N-1:0] m_out;
    int           m_ptr;

    nand_slot_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_y    (gate_y),
        .slot_busy (slot_busy)
    );

    // ---------------- clock / reset / package model ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial gate_y = 4'hF;
    always @(gate_a, gate_b) gate_y <= #10 ~(gate_a & gate_b);

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r);
        @(negedge clk);
        rst  = r;
        pend = (pend & ~acc_seen) | hold_mask;
        if (r) pend = hold_mask;
        if (rand_ops) begin
            opa = N'($urandom);
            opb = N'($urandom);
        end
        req_valid = pend;
        req_a     = opa;
        req_b     = opb;
    endtask

    always @(negedge clk) begin
        #4;
        acc_seen = req_valid & req_ready;
    end

    // ---------------- reference model ----------------
    always @(negedge clk) begin
        int           win;
        int           fs;
        logic [N-1:0] exp_ready;
        logic [3:0]   e_busy, e_a, e_b;
        #4;
        win = -1;
        fs  = -1;
        for (int s = NS - 1; s >= 0; s--) if (m_rem[s] == 0) fs = s;
        if (fs >= 0) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (win < 0 && req_valid[idx] && !m_out[idx]) win = idx;
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        for (int s = 0; s < NS; s++) begin
            e_busy[s] = (m_rem[s] != 0);
            e_a[s]    = m_a[s];
            e_b[s]    = m_b[s];
        end
        if (armed) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("slot_busy", 32'(slot_busy), 32'(e_busy));
            check("gate_a", 32'(gate_a), 32'(e_a));
            check("gate_b", 32'(gate_b), 32'(e_b));
        end
        if (rst) begin
            armed = 1'b1;
            m_ptr = N - 1;
            m_out = '0;
            for (int s = 0; s < NS; s++) begin
                m_rem[s] = 0; m_own[s] = 0; m_a[s] = 1'b0; m_b[s] = 1'b0;
            end
            // in-flight operations are dropped; only a pulse already due now survives
            for (int k = exp_q.size() - 1; k >= 0; k--)
                if (int'(exp_q[k][32:1]) > cyc) exp_q.delete(k);
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (m_rem[s] == 1) begin
                    m_rem[s] = 0;
                    m_out[m_own[s]] = 1'b0;
                    m_a[s] = 1'b0;
                    m_b[s] = 1'b0;
                end else if (m_rem[s] > 1) begin
                    m_rem[s]--;
                end
            end
            if (win >= 0) begin
                m_rem[fs] = S;
                m_own[fs] = win;
                m_a[fs]   = req_a[win];
                m_b[fs]   = req_b[win];
                m_out[win] = 1'b1;
                m_ptr      = win;
                exp_q.push_back({3'(win), 32'(cyc + S + 1), ~(req_a[win] & req_b[win])});
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        #4;
        if (armed) begin
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    int hit;
                    hit = -1;
                    for (int k = 0; k < exp_q.size(); k++)
                        if (hit < 0 && int'(exp_q[k][EW-1 -: 3]) == i) hit = k;
                    if (hit < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected at cycle %0d: requester %0d got rsp_valid, expected none", cyc, i);
                    end else begin
                        check("rsp_cycle", 32'(cyc), exp_q[hit][32:1]);
                        check("rsp_y", 32'(rsp_y[i]), 32'(exp_q[hit][0]));
                        exp_q.delete(hit);
                    end
                end
            end
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (int'(exp_q[k][32:1]) < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing at cycle %0d: requester %0d got no rsp_valid, expected one at cycle %0d",
                             cyc, exp_q[k][EW-1 -: 3], exp_q[k][32:1]);
                    exp_q.delete(k);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        m_ptr = N - 1; m_out = '0;
        for (int s = 0; s < NS; s++) begin
            m_rem[s] = 0; m_own[s] = 0; m_a[s] = 1'b0; m_b[s] = 1'b0;
        end
        repeat (3) step(1'b1);

        // single op: 1 NAND 1 on requester 0
        opa = N'(1); opb = N'(1); pend = N'(1);
        repeat (6) step(1'b0);

        // four requesters at once, 0 NAND 1
        opa = '0; opb = '1; pend = N'(6'b001111);
        repeat (10) step(1'b0);

        // fairness between requesters 0 and 1 with reissue in the response cycle
        rand_ops = 1'b1; hold_mask = N'(6'b000011);
        repeat (70) step(1'b0);
        hold_mask = '0; pend = '0;
        repeat (5) step(1'b0);

        // all six requesters: slots fill, then grants follow frees
        hold_mask = '1;
        repeat (16) step(1'b0);
        hold_mask = '0; pend = '0;
        repeat (5) step(1'b0);

        // reset in the second settle cycle of an operation
        rand_ops = 1'b0; opa = '1; opb = '1; pend = N'(1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        pend = N'(6'b100001);
        repeat (6) step(1'b0);

        // requester 2 reissues 1 NAND 0 in every response cycle
        opa = N'(6'b000100); opb = '0; hold_mask = N'(6'b000100);
        repeat (12) step(1'b0);
        hold_mask = '0; pend = '0;
        repeat (5) step(1'b0);

        // random traffic with occasional reset
        rand_ops = 1'b1;
        for (int c = 0; c < 400; c++) begin
            pend = pend | (N'($urandom) & N'($urandom));
            step($urandom_range(0, 99) == 0);
        end

        // drain
        pend = '0; hold_mask = '0;
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) step(1'b0);
        step(1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
